// File: rtl/f_ifu_pkg.sv
// Shared fetch/exception constants for the P8 core (F stage, CP0, M-stage exception logic).
package f_ifu_pkg;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] PC_HANDLER = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // One F/D pipeline entry
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc_code;
    logic        bd;
  } fd_entry_t;

  // Fetch address error: misaligned or outside the instruction memory window (unsigned compare)
  function automatic logic fetch_adel(input logic [31:0] pc,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/f_ifu_if.sv
// Instruction-memory fetch bus: address out of the fetch stage, word back (combinational read).
interface f_ifu_if;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;

  modport master (output F_PC, input F_Instr);
  modport slave  (input F_PC, output F_Instr);
endinterface

// File: rtl/f_ifu_f_d_reg.sv
// F/D pipeline register: reset, flush to handler, stall hold, eret squash, normal capture.
module f_d_reg #(
  parameter logic [31:0] PC_RESET = f_ifu_pkg::PC_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic        squash,
  input  logic [31:0] flush_pc,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  input  logic        f_adel,
  input  logic        bd_in,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_exc_code,
  output logic        d_bd
);
  import f_ifu_pkg::*;

  fd_entry_t fd_q;

  // Flush beats stall; stall beats squash. Squashed/flushed entries are exception-free nops.
  always_ff @(posedge clk) begin
    if (reset) begin
      fd_q <= '{pc: PC_RESET, instr: '0, exc_code: EXC_NONE, bd: 1'b0};
    end else if (flush) begin
      fd_q <= '{pc: flush_pc, instr: '0, exc_code: EXC_NONE, bd: 1'b0};
    end else if (en) begin
      if (squash) begin
        fd_q <= '{pc: f_pc, instr: '0, exc_code: EXC_NONE, bd: 1'b0};
      end else begin
        fd_q <= '{pc:       f_pc,
                  instr:    f_adel ? '0 : f_instr,
                  exc_code: f_adel ? EXC_ADEL : EXC_NONE,
                  bd:       bd_in};
      end
    end
  end

  assign d_pc       = fd_q.pc;
  assign d_instr    = fd_q.instr;
  assign d_exc_code = fd_q.exc_code;
  assign d_bd       = fd_q.bd;

endmodule

// File: rtl/f_ifu.sv
// Fetch stage: PC register with exception/eret redirection, AdEL check, and the F/D register.
module f_ifu #(
  parameter logic [31:0] PC_RESET   = f_ifu_pkg::PC_RESET,
  parameter logic [31:0] PC_HANDLER = f_ifu_pkg::PC_HANDLER,
  parameter logic [31:0] IM_LO      = f_ifu_pkg::IM_LO,
  parameter logic [31:0] IM_HI      = f_ifu_pkg::IM_HI
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    F_newPC,
  input  logic           stall,
  input  logic           Req,
  input  logic           D_eret,
  input  logic [31:0]    EPC,
  input  logic           D_BJ,
  f_ifu_if.master        im,
  output logic [31:0]    D_PC,
  output logic [31:0]    D_Instr,
  output logic [4:0]     D_ExcCode,
  output logic           D_BD
);
  import f_ifu_pkg::*;

  logic [31:0] pc_q;
  logic        f_adel;

  // Fetch address exception, internal only
  always_comb begin
    f_adel = fetch_adel(pc_q, IM_LO, IM_HI);
  end

  // PC update: reset, exception entry, stall hold, eret return, else next-PC
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_RESET;
    end else if (Req) begin
      pc_q <= PC_HANDLER;
    end else if (!stall) begin
      pc_q <= D_eret ? EPC : F_newPC;
    end
  end

  assign im.F_PC = pc_q;

  f_d_reg #(
    .PC_RESET (PC_RESET)
  ) u_f_d_reg (
    .clk        (clk),
    .reset      (reset),
    .en         (!stall),
    .flush      (Req),
    .squash     (D_eret),
    .flush_pc   (PC_HANDLER),
    .f_pc       (pc_q),
    .f_instr    (im.F_Instr),
    .f_adel     (f_adel),
    .bd_in      (D_BJ),
    .d_pc       (D_PC),
    .d_instr    (D_Instr),
    .d_exc_code (D_ExcCode),
    .d_bd       (D_BD)
  );

endmodule

// File: tb/tb_f_ifu.sv
// Scoreboard bench for f_ifu: directed steps push hand-computed post-edge state; a monitor pops and compares.
module tb_f_ifu;

  typedef struct {
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic [31:0] dinstr;
    logic [4:0]  exc;
    logic        bd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] F_newPC = '0;
  logic        stall = 1'b0;
  logic        Req = 1'b0;
  logic        D_eret = 1'b0;
  logic [31:0] EPC = '0;
  logic        D_BJ = 1'b0;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic [4:0]  D_ExcCode;
  logic        D_BD;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        sb[$];

  f_ifu_if im ();

  always #5 clk = ~clk;

  f_ifu #(
    .PC_RESET   (32'h0000_3000),
    .PC_HANDLER (32'h0000_4180),
    .IM_LO      (32'h0000_3000),
    .IM_HI      (32'h0000_6FFC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .F_newPC   (F_newPC),
    .stall     (stall),
    .Req       (Req),
    .D_eret    (D_eret),
    .EPC       (EPC),
    .D_BJ      (D_BJ),
    .im        (im.master),
    .D_PC      (D_PC),
    .D_Instr   (D_Instr),
    .D_ExcCode (D_ExcCode),
    .D_BD      (D_BD)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  // Monitor: every edge with a pending expectation is compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("F_PC",      im.F_PC,           e.fpc);
        chk("D_PC",      D_PC,              e.dpc);
        chk("D_Instr",   D_Instr,           e.dinstr);
        chk("D_ExcCode", {27'd0, D_ExcCode}, {27'd0, e.exc});
        chk("D_BD",      {31'd0, D_BD},      {31'd0, e.bd});
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the following edge
  task automatic step(input logic rst, input logic stl, input logic rq, input logic er,
                      input logic bj, input logic [31:0] npc, input logic [31:0] epc_v,
                      input logic [31:0] instr,
                      input logic [31:0] e_fpc, input logic [31:0] e_dpc,
                      input logic [31:0] e_di, input logic [4:0] e_exc, input logic e_bd);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    stall      = stl;
    Req        = rq;
    D_eret     = er;
    D_BJ       = bj;
    F_newPC    = npc;
    EPC        = epc_v;
    im.F_Instr = instr;
    e.fpc = e_fpc; e.dpc = e_dpc; e.dinstr = e_di; e.exc = e_exc; e.bd = e_bd;
    sb.push_back(e);
  endtask

  initial begin
    im.F_Instr = '0;
    //    rst stl rq er bj  newPC         EPC           F_Instr        exp F_PC      exp D_PC      exp D_Instr   exc  bd
    step(1, 0, 0, 0, 0, 32'h0000_0000, 32'h0,        32'h1111_1111, 32'h0000_3000, 32'h0000_3000, 32'h0,        5'd0, 0);
    step(1, 0, 0, 0, 0, 32'h0000_0000, 32'h0,        32'h1111_1111, 32'h0000_3000, 32'h0000_3000, 32'h0,        5'd0, 0);
    // sequential fetch
    step(0, 0, 0, 0, 0, 32'h0000_3004, 32'h0,        32'h2400_3000, 32'h0000_3004, 32'h0000_3000, 32'h2400_3000, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3008, 32'h0,        32'h2400_3004, 32'h0000_3008, 32'h0000_3004, 32'h2400_3004, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_300C, 32'h0,        32'h2400_3008, 32'h0000_300C, 32'h0000_3008, 32'h2400_3008, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3010, 32'h0,        32'h2400_300C, 32'h0000_3010, 32'h0000_300C, 32'h2400_300C, 5'd0, 0);
    // three stalled edges: everything holds
    step(0, 1, 0, 0, 0, 32'h0000_3014, 32'h0,        32'h2400_3010, 32'h0000_3010, 32'h0000_300C, 32'h2400_300C, 5'd0, 0);
    step(0, 1, 0, 0, 0, 32'h0000_3014, 32'h0,        32'h2400_3010, 32'h0000_3010, 32'h0000_300C, 32'h2400_300C, 5'd0, 0);
    step(0, 1, 0, 0, 0, 32'h0000_3014, 32'h0,        32'h2400_3010, 32'h0000_3010, 32'h0000_300C, 32'h2400_300C, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3014, 32'h0,        32'h2400_3010, 32'h0000_3014, 32'h0000_3010, 32'h2400_3010, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3018, 32'h0,        32'h2400_3014, 32'h0000_3018, 32'h0000_3014, 32'h2400_3014, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_301C, 32'h0,        32'h2400_3018, 32'h0000_301C, 32'h0000_3018, 32'h2400_3018, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3020, 32'h0,        32'h2400_301C, 32'h0000_3020, 32'h0000_301C, 32'h2400_301C, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3024, 32'h0,        32'h2400_3020, 32'h0000_3024, 32'h0000_3020, 32'h2400_3020, 5'd0, 0);
    // branch at 0x3020 in D: delay slot 0x3024 tagged BD, target 0x3100
    step(0, 0, 0, 0, 1, 32'h0000_3100, 32'h0,        32'h2400_3024, 32'h0000_3100, 32'h0000_3024, 32'h2400_3024, 5'd0, 1);
    // misaligned target
    step(0, 0, 0, 0, 0, 32'h0000_3001, 32'h0,        32'h2400_3100, 32'h0000_3001, 32'h0000_3100, 32'h2400_3100, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3104, 32'h0,        32'h2400_3001, 32'h0000_3104, 32'h0000_3001, 32'h0,        5'd4, 0);
    // upper bound: 0x7000 illegal, 0x6FFC legal; lower bound: 0x2FFC illegal
    step(0, 0, 0, 0, 0, 32'h0000_7000, 32'h0,        32'h2400_3104, 32'h0000_7000, 32'h0000_3104, 32'h2400_3104, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_6FFC, 32'h0,        32'h2400_7000, 32'h0000_6FFC, 32'h0000_7000, 32'h0,        5'd4, 0);
    step(0, 0, 0, 0, 0, 32'h0000_2FFC, 32'h0,        32'h2400_6FFC, 32'h0000_2FFC, 32'h0000_6FFC, 32'h2400_6FFC, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3000, 32'h0,        32'h2400_2FFC, 32'h0000_3000, 32'h0000_2FFC, 32'h0,        5'd4, 0);
    // Req beats stall and eret
    step(0, 1, 1, 1, 1, 32'h0000_3004, 32'h0000_3040, 32'h2400_3000, 32'h0000_4180, 32'h0000_4180, 32'h0,        5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_4184, 32'h0,        32'h2400_4180, 32'h0000_4184, 32'h0000_4180, 32'h2400_4180, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_4188, 32'h0,        32'h2400_4184, 32'h0000_4188, 32'h0000_4184, 32'h2400_4184, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_418C, 32'h0,        32'h2400_4188, 32'h0000_418C, 32'h0000_4188, 32'h2400_4188, 5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_4190, 32'h0,        32'h2400_418C, 32'h0000_4190, 32'h0000_418C, 32'h2400_418C, 5'd0, 0);
    // eret held by stall, then redirects to EPC and squashes the word at 0x4190
    step(0, 1, 0, 1, 0, 32'h0000_4194, 32'h0000_3040, 32'h2400_4190, 32'h0000_4190, 32'h0000_418C, 32'h2400_418C, 5'd0, 0);
    step(0, 0, 0, 1, 1, 32'h0000_4194, 32'h0000_3040, 32'h2400_4190, 32'h0000_3040, 32'h0000_4190, 32'h0,        5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3044, 32'h0,        32'h2400_3040, 32'h0000_3044, 32'h0000_3040, 32'h2400_3040, 5'd0, 0);
    // BD holds across a stall
    step(0, 0, 0, 0, 1, 32'h0000_3048, 32'h0,        32'h2400_3044, 32'h0000_3048, 32'h0000_3044, 32'h2400_3044, 5'd0, 1);
    step(0, 1, 0, 0, 0, 32'h0000_304C, 32'h0,        32'h2400_3048, 32'h0000_3048, 32'h0000_3044, 32'h2400_3044, 5'd0, 1);
    step(0, 0, 0, 0, 0, 32'h0000_304C, 32'h0,        32'h2400_3048, 32'h0000_304C, 32'h0000_3048, 32'h2400_3048, 5'd0, 0);
    // reset mid-stream wins over Req and stall
    step(1, 1, 1, 1, 1, 32'h0000_5000, 32'h0000_3040, 32'h2400_304C, 32'h0000_3000, 32'h0000_3000, 32'h0,        5'd0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3004, 32'h0,        32'h2400_3000, 32'h0000_3004, 32'h0000_3000, 32'h2400_3000, 5'd0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
